// File: rtl/sphere_scene_sequencer_pkg.sv
// Shared definitions for the sphere scene sequencer: bus widths, object word
// field positions, default miss distance, FSM state encoding, colour shading.
// Imported by sphere_scene_sequencer and scene_tag_pipe.
package sphere_scene_sequencer_pkg;

    // Bus widths
    localparam int RAY_INIT_W = 28;  // {x10, y10, z8}
    localparam int RAY_DIR_W  = 31;
    localparam int OBJ_W      = 48;  // {colour12, radius8, x10, y10, z8}
    localparam int T_W        = 10;
    localparam int COL_W      = 12;

    // Object word field positions
    localparam int COL_MSB = 47;
    localparam int COL_LSB = 36;
    localparam int RAD_MSB = 35;
    localparam int RAD_LSB = 28;
    localparam int X_MSB   = 27;
    localparam int X_LSB   = 18;
    localparam int Y_MSB   = 17;
    localparam int Y_LSB   = 8;
    localparam int Z_MSB   = 7;
    localparam int Z_LSB   = 0;

    // Distance the tracer reports when the ray misses an object
    localparam logic [T_W-1:0] T_MISS_DEFAULT = 10'h3FF;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_ISSUE = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } seq_state_e;

    // Darken each 4-bit channel by 'dim', saturating at zero.
    function automatic logic [COL_W-1:0] shade_color(input logic [COL_W-1:0] col,
                                                     input logic [3:0]       dim);
        logic [COL_W-1:0] res;
        logic [3:0]       ch;
        res = '0;
        for (int c = 0; c < 3; c++) begin
            ch = col[c*4 +: 4];
            res[c*4 +: 4] = (ch > dim) ? (ch - dim) : 4'd0;
        end
        return res;
    endfunction

endpackage

// File: rtl/scene_tag_pipe.sv
// Tag shift register that follows each object through the sphere tracer so the
// returning distance can be matched with the object's index and colour.
// Ports: in_* tag pushed this edge; out_* tag of the oldest stage; inflight_o
// is set while any stage other than the output stage holds a valid tag.
module scene_tag_pipe
    import sphere_scene_sequencer_pkg::*;
#(
    parameter int DEPTH = 3,   // stages, >= 1
    parameter int IDX_W = 3
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_vld_i,
    input  logic [IDX_W-1:0] in_idx_i,
    input  logic [COL_W-1:0] in_col_i,
    output logic             out_vld_o,
    output logic [IDX_W-1:0] out_idx_o,
    output logic [COL_W-1:0] out_col_o,
    output logic             inflight_o
);

    logic [DEPTH-1:0] vld_q;
    logic [IDX_W-1:0] idx_q [DEPTH];
    logic [COL_W-1:0] col_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                idx_q[i] <= '0;
                col_q[i] <= '0;
            end
        end else begin
            vld_q[0] <= in_vld_i;
            idx_q[0] <= in_idx_i;
            col_q[0] <= in_col_i;
            for (int i = 1; i < DEPTH; i++) begin
                vld_q[i] <= vld_q[i-1];
                idx_q[i] <= idx_q[i-1];
                col_q[i] <= col_q[i-1];
            end
        end
    end

    assign out_vld_o = vld_q[DEPTH-1];
    assign out_idx_o = idx_q[DEPTH-1];
    assign out_col_o = col_q[DEPTH-1];

    // The output stage is consumed this cycle, so only earlier stages count
    // as still in flight.
    always_comb begin
        inflight_o = 1'b0;
        for (int i = 0; i < DEPTH-1; i++) begin
            inflight_o = inflight_o | vld_q[i];
        end
    end

endmodule

// File: rtl/sphere_scene_sequencer.sv
// Sphere scene sequencer: accepts one ray, streams every ROM object into the
// sphere tracer one per cycle, keeps the nearest hit and presents it as a pixel.
// Ports: ray_* request (valid/ready), obj_* ROM (1-cycle read), trc_* tracer
// interface, pix_* result (valid/ready). Optional macro DEPTH_SHADE_EN darkens
// the pixel colour by the top four bits of the nearest distance.
module sphere_scene_sequencer
    import sphere_scene_sequencer_pkg::*;
#(
    parameter int              N_OBJ      = 8,
    parameter int              OBJ_AW     = 3,
    parameter int              TRACER_LAT = 2,
    parameter logic [T_W-1:0]  T_MISS     = T_MISS_DEFAULT
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  ray_valid_i,
    output logic                  ray_ready_o,
    input  logic [RAY_INIT_W-1:0] ray_init_i,
    input  logic [RAY_DIR_W-1:0]  ray_dir_i,
    output logic [OBJ_AW-1:0]     obj_addr_o,
    input  logic [OBJ_W-1:0]      obj_data_i,
    output logic [RAY_INIT_W-1:0] trc_init_o,
    output logic [RAY_DIR_W-1:0]  trc_dir_o,
    output logic [OBJ_W-1:0]      trc_object_o,
    input  logic [T_W-1:0]        trc_t_i,
    output logic                  pix_valid_o,
    input  logic                  pix_ready_i,
    output logic [COL_W-1:0]      pix_color_o,
    output logic [T_W-1:0]        pix_t_o,
    output logic                  pix_hit_o
);

    localparam logic [OBJ_AW-1:0] LAST_IDX = OBJ_AW'(N_OBJ - 1);

    seq_state_e state_q, state_d;

    logic [OBJ_AW-1:0]     obj_addr_q,   obj_addr_d;
    logic [OBJ_AW-1:0]     issue_idx_q,  issue_idx_d;
    logic [RAY_INIT_W-1:0] trc_init_q,   trc_init_d;
    logic [RAY_DIR_W-1:0]  trc_dir_q,    trc_dir_d;
    logic [OBJ_W-1:0]      trc_object_q, trc_object_d;
    logic [T_W-1:0]        best_t_q,     best_t_d;
    logic [COL_W-1:0]      best_col_q,   best_col_d;
    logic [OBJ_AW-1:0]     best_idx_q,   best_idx_d;
    logic                  pix_valid_q,  pix_valid_d;
    logic [COL_W-1:0]      pix_color_q,  pix_color_d;
    logic [T_W-1:0]        pix_t_q,      pix_t_d;
    logic                  pix_hit_q,    pix_hit_d;

    logic              tag_in_vld;
    logic              tag_out_vld;
    logic [OBJ_AW-1:0] tag_out_idx;
    logic [COL_W-1:0]  tag_out_col;
    logic              tags_inflight;

    logic ray_accept;
    logic drain_done;
    logic closer_hit;

    // Stage 0 of the tag pipe loads on the same edge as trc_object, so after
    // TRACER_LAT further shifts the output stage lines up with trc_t.
    assign tag_in_vld = (state_q == ST_ISSUE);

    scene_tag_pipe #(
        .DEPTH (TRACER_LAT + 1),
        .IDX_W (OBJ_AW)
    ) u_tag_pipe (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .in_vld_i   (tag_in_vld),
        .in_idx_i   (issue_idx_q),
        .in_col_i   (obj_data_i[COL_MSB:COL_LSB]),
        .out_vld_o  (tag_out_vld),
        .out_idx_o  (tag_out_idx),
        .out_col_o  (tag_out_col),
        .inflight_o (tags_inflight)
    );

    assign ray_accept = (state_q == ST_IDLE) && ray_valid_i;
    // Last tag is being compared this cycle: result can be registered now.
    assign drain_done = (state_q == ST_DRAIN) && !tags_inflight;

    // Equal distances resolve to the lower object index; a miss never wins.
    assign closer_hit = tag_out_vld && (trc_t_i != T_MISS) &&
                        ((trc_t_i < best_t_q) ||
                         ((trc_t_i == best_t_q) && (tag_out_idx < best_idx_q)));

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (ray_valid_i) state_d = ST_FETCH;
            ST_FETCH: state_d = ST_ISSUE;
            ST_ISSUE: if (issue_idx_q == LAST_IDX) state_d = ST_DRAIN;
            ST_DRAIN: if (!tags_inflight) state_d = ST_DONE;
            ST_DONE:  if (pix_ready_i) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Datapath next-state
    always_comb begin
        obj_addr_d   = obj_addr_q;
        issue_idx_d  = issue_idx_q;
        trc_init_d   = trc_init_q;
        trc_dir_d    = trc_dir_q;
        trc_object_d = trc_object_q;
        best_t_d     = best_t_q;
        best_col_d   = best_col_q;
        best_idx_d   = best_idx_q;
        pix_valid_d  = pix_valid_q;
        pix_color_d  = pix_color_q;
        pix_t_d      = pix_t_q;
        pix_hit_d    = pix_hit_q;

        if (ray_accept) begin
            trc_init_d  = ray_init_i;
            trc_dir_d   = ray_dir_i;
            obj_addr_d  = '0;
            issue_idx_d = '0;
            best_t_d    = T_MISS;
            best_col_d  = '0;
            best_idx_d  = '1;
        end

        if (closer_hit) begin
            best_t_d   = trc_t_i;
            best_col_d = tag_out_col;
            best_idx_d = tag_out_idx;
        end

        // Address runs one ahead of the issued object to cover ROM latency,
        // and parks on the last object instead of wrapping.
        if ((state_q == ST_FETCH) || (state_q == ST_ISSUE)) begin
            if (obj_addr_q != LAST_IDX) begin
                obj_addr_d = obj_addr_q + 1'b1;
            end
        end

        if (state_q == ST_ISSUE) begin
            trc_object_d = obj_data_i;
            if (issue_idx_q != LAST_IDX) begin
                issue_idx_d = issue_idx_q + 1'b1;
            end
        end

        if (drain_done) begin
            pix_valid_d = 1'b1;
            pix_t_d     = best_t_d;
            pix_hit_d   = (best_t_d != T_MISS);
`ifdef DEPTH_SHADE_EN
            pix_color_d = shade_color(best_col_d, best_t_d[T_W-1:T_W-4]);
`else
            pix_color_d = best_col_d;
`endif
        end

        if ((state_q == ST_DONE) && pix_ready_i) begin
            pix_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            obj_addr_q   <= '0;
            issue_idx_q  <= '0;
            trc_init_q   <= '0;
            trc_dir_q    <= '0;
            trc_object_q <= '0;
            best_t_q     <= T_MISS;
            best_col_q   <= '0;
            best_idx_q   <= '1;
            pix_valid_q  <= 1'b0;
            pix_color_q  <= '0;
            pix_t_q      <= T_MISS;
            pix_hit_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            obj_addr_q   <= obj_addr_d;
            issue_idx_q  <= issue_idx_d;
            trc_init_q   <= trc_init_d;
            trc_dir_q    <= trc_dir_d;
            trc_object_q <= trc_object_d;
            best_t_q     <= best_t_d;
            best_col_q   <= best_col_d;
            best_idx_q   <= best_idx_d;
            pix_valid_q  <= pix_valid_d;
            pix_color_q  <= pix_color_d;
            pix_t_q      <= pix_t_d;
            pix_hit_q    <= pix_hit_d;
        end
    end

    assign ray_ready_o  = (state_q == ST_IDLE);
    assign obj_addr_o   = obj_addr_q;
    assign trc_init_o   = trc_init_q;
    assign trc_dir_o    = trc_dir_q;
    assign trc_object_o = trc_object_q;
    assign pix_valid_o  = pix_valid_q;
    assign pix_color_o  = pix_color_q;
    assign pix_t_o      = pix_t_q;
    assign pix_hit_o    = pix_hit_q;

endmodule
